// File: rtl/overcooked_pkg.sv
`default_nettype none
// ============================================================================
// Module   : overcooked_pkg
// Purpose  : Shared game-logic types: facing direction, coordinate width and
//            the player mover state encoding.
// Revision : 1.0  initial release
// ============================================================================
package overcooked_pkg;

  localparam int COORD_W = 4;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUERY = 2'd1,
    HOLD  = 2'd2
  } mover_state_t;

endpackage
`default_nettype wire

// File: rtl/player_mover_if.sv
`default_nettype none
// ============================================================================
// Module   : player_mover_if
// Purpose  : Button, map-query and position signals of one player mover.
// Revision : 1.0  initial release
// ============================================================================
interface player_mover_if;
  import overcooked_pkg::*;

  logic               enable_in;
  logic               left_in;
  logic               right_in;
  logic               up_in;
  logic               down_in;
  logic               chop_in;
  logic               blocked_in;
  logic [COORD_W-1:0] query_x_out;
  logic [COORD_W-1:0] query_y_out;
  logic [COORD_W-1:0] player_x_out;
  logic [COORD_W-1:0] player_y_out;
  dir_t               dir_out;
  logic               moved_out;
  logic               chop_out;

  // master: the mover itself; slave: debouncers, grid map and consumers
  modport master (
    input  enable_in, left_in, right_in, up_in, down_in, chop_in, blocked_in,
    output query_x_out, query_y_out, player_x_out, player_y_out,
           dir_out, moved_out, chop_out
  );

  modport slave (
    output enable_in, left_in, right_in, up_in, down_in, chop_in, blocked_in,
    input  query_x_out, query_y_out, player_x_out, player_y_out,
           dir_out, moved_out, chop_out
  );

endinterface
`default_nettype wire

// File: rtl/move_repeat_timer.sv
`default_nettype none
// ============================================================================
// Module   : move_repeat_timer
// Purpose  : Loadable down-counter that stops at zero; flags zero.
// Revision : 1.0  initial release
// ============================================================================
module move_repeat_timer #(
  parameter int WIDTH = 25
) (
  input  wire logic             clock_in,
  input  wire logic             reset_in,
  input  wire logic             load_in,
  input  wire logic [WIDTH-1:0] load_value_in,
  input  wire logic             clear_in,
  output logic                  zero_out
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock_in) begin
    if (reset_in || clear_in) begin
      r_count <= '0;
    end else if (load_in) begin
      r_count <= load_value_in;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign zero_out = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/player_mover.sv
`default_nettype none
// ============================================================================
// Module   : player_mover
// Purpose  : Grid movement controller with map query and hold-to-repeat.
// Revision : 1.0  initial release
// ============================================================================
module player_mover
  import overcooked_pkg::*;
#(
  parameter int GRID_W       = 16,
  parameter int GRID_H       = 12,
  parameter int START_X      = 1,
  parameter int START_Y      = 1,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  wire logic      clock_in,
  input  wire logic      reset_in,
  player_mover_if.master bus
);

  localparam int                        c_cnt_w   = 25;
  localparam logic signed [COORD_W:0]   c_max_x   = (COORD_W+1)'(GRID_W - 1);
  localparam logic signed [COORD_W:0]   c_max_y   = (COORD_W+1)'(GRID_H - 1);
  // Counts include the QUERY cycle: first repeat QUERY lands REPEAT_DELAY
  // cycles after the first QUERY, later ones every REPEAT_RATE+1 cycles.
  localparam logic [c_cnt_w-1:0]        c_first_load = c_cnt_w'(REPEAT_DELAY - 2);
  localparam logic [c_cnt_w-1:0]        c_rate_load  = c_cnt_w'(REPEAT_RATE - 1);

  mover_state_t              r_state, w_state_nxt;
  dir_t                      r_dir, w_sel_dir, w_step_dir;
  logic [COORD_W-1:0]        r_x, r_y;
  logic signed [COORD_W:0]   r_tx, r_ty, w_tx, w_ty;
  logic                      r_moved, r_chop, r_repeat;
  logic                      w_any, w_held, w_zero, w_in_bounds;
  logic                      w_press, w_retrigger, w_commit, w_load, w_clear;
  logic [c_cnt_w-1:0]        w_load_val;

  assign w_any = bus.up_in | bus.down_in | bus.left_in | bus.right_in;

  always_comb begin
    if (bus.up_in)        w_sel_dir = UP;
    else if (bus.down_in) w_sel_dir = DOWN;
    else if (bus.left_in) w_sel_dir = LEFT;
    else                  w_sel_dir = RIGHT;
  end

  always_comb begin
    case (r_dir)
      UP:      w_held = bus.up_in;
      DOWN:    w_held = bus.down_in;
      LEFT:    w_held = bus.left_in;
      default: w_held = bus.right_in;
    endcase
  end

  // Signed one-bit-wider target so stepping off 0 or 15 never wraps
  assign w_step_dir = (r_state == IDLE) ? w_sel_dir : r_dir;

  always_comb begin
    w_tx = signed'({1'b0, r_x});
    w_ty = signed'({1'b0, r_y});
    case (w_step_dir)
      UP:      w_ty = signed'({1'b0, r_y}) - 5'sd1;
      DOWN:    w_ty = signed'({1'b0, r_y}) + 5'sd1;
      LEFT:    w_tx = signed'({1'b0, r_x}) - 5'sd1;
      default: w_tx = signed'({1'b0, r_x}) + 5'sd1;
    endcase
  end

  assign w_in_bounds = (r_tx >= 5'sd0) && (r_tx <= c_max_x) &&
                       (r_ty >= 5'sd0) && (r_ty <= c_max_y);

  always_ff @(posedge clock_in) begin
    if (reset_in) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = QUERY;
      QUERY:   w_state_nxt = HOLD;
      HOLD: begin
        if (!w_held)     w_state_nxt = IDLE;
        else if (w_zero) w_state_nxt = QUERY;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!bus.enable_in) w_state_nxt = IDLE;
  end

  always_comb begin
    w_press     = 1'b0;
    w_retrigger = 1'b0;
    w_commit    = 1'b0;
    w_load      = 1'b0;
    w_clear     = (w_state_nxt == IDLE);
    w_load_val  = r_repeat ? c_rate_load : c_first_load;
    if (bus.enable_in) begin
      case (r_state)
        IDLE:  w_press = w_any;
        QUERY: begin
          w_load   = 1'b1;
          w_commit = w_in_bounds & ~bus.blocked_in;
        end
        HOLD:    w_retrigger = w_held & w_zero;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_x      <= COORD_W'(START_X);
      r_y      <= COORD_W'(START_Y);
      r_tx     <= (COORD_W+1)'(START_X);
      r_ty     <= (COORD_W+1)'(START_Y);
      r_dir    <= DOWN;
      r_moved  <= 1'b0;
      r_chop   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_moved <= w_commit;
      r_chop  <= bus.enable_in & bus.chop_in & (r_state == IDLE) & ~w_any;
      if (w_press || w_retrigger) begin
        r_tx <= w_tx;
        r_ty <= w_ty;
      end
      if (w_press) begin
        r_dir    <= w_sel_dir;
        r_repeat <= 1'b0;
      end
      if (w_load) r_repeat <= 1'b1;
      if (w_commit) begin
        r_x <= r_tx[COORD_W-1:0];
        r_y <= r_ty[COORD_W-1:0];
      end
    end
  end

  move_repeat_timer #(.WIDTH(c_cnt_w)) u_timer (
    .clock_in      (clock_in),
    .reset_in      (reset_in),
    .load_in       (w_load),
    .load_value_in (w_load_val),
    .clear_in      (w_clear),
    .zero_out      (w_zero)
  );

  // Out-of-bounds targets are never shown to the map
  assign bus.query_x_out  = (r_state == QUERY && w_in_bounds) ? r_tx[COORD_W-1:0] : r_x;
  assign bus.query_y_out  = (r_state == QUERY && w_in_bounds) ? r_ty[COORD_W-1:0] : r_y;
  assign bus.player_x_out = r_x;
  assign bus.player_y_out = r_y;
  assign bus.dir_out      = r_dir;
  assign bus.moved_out    = r_moved;
  assign bus.chop_out     = r_chop;

endmodule
`default_nettype wire

// File: tb/tb_player_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_mover
// Purpose  : Directed self-checking bench for player_mover on a 4x4 grid.
// Revision : 1.0  initial release
// ============================================================================
module tb_player_mover;
  import overcooked_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  player_mover_if bus ();

  player_mover #(
    .GRID_W(4), .GRID_H(4), .START_X(1), .START_Y(1),
    .REPEAT_DELAY(8), .REPEAT_RATE(4)
  ) dut (
    .clock_in (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int d, input logic v);
    case (d)
      0:       bus.up_in    = v;
      1:       bus.down_in  = v;
      2:       bus.left_in  = v;
      default: bus.right_in = v;
    endcase
  endtask

  // One-cycle press, then wait for the mover to settle back in IDLE
  task automatic step_dir(input int d);
    set_btn(d, 1'b1);
    tick();
    set_btn(d, 1'b0);
    tick();
    tick();
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(bus.player_x_out), 32'(x));
    chk({tag, "_y"}, 32'(bus.player_y_out), 32'(y));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_x;
    bus.enable_in = 1'b1; bus.chop_in = 1'b0; bus.blocked_in = 1'b0;
    bus.up_in = 1'b0; bus.down_in = 1'b0; bus.left_in = 1'b0; bus.right_in = 1'b0;
    tick();
    tick();
    chk_pos("rst_pos", 1, 1);
    chk("rst_dir", 32'(bus.dir_out), 32'(DOWN));
    chk("rst_moved", 32'(bus.moved_out), 0);
    chk("rst_chop", 32'(bus.chop_out), 0);
    chk("rst_qx", 32'(bus.query_x_out), 1);
    chk("rst_qy", 32'(bus.query_y_out), 1);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;

    // 1: single right press
    bus.right_in = 1'b1;
    tick();
    bus.right_in = 1'b0;
    chk("t1_qx", 32'(bus.query_x_out), 2);
    chk("t1_qy", 32'(bus.query_y_out), 1);
    chk("t1_moved_early", 32'(bus.moved_out), 0);
    chk("t1_dir", 32'(bus.dir_out), 32'(RIGHT));
    tick();
    chk_pos("t1_pos", 2, 1);
    chk("t1_moved", 32'(bus.moved_out), 1);
    tick();
    chk("t1_moved_pulse", 32'(bus.moved_out), 0);
    tick();
    step_dir(2);
    chk_pos("t1_back", 1, 1);

    // 2: blocked up
    bus.up_in = 1'b1; bus.blocked_in = 1'b1;
    tick();
    bus.up_in = 1'b0;
    chk("t2_qy", 32'(bus.query_y_out), 0);
    chk("t2_dir", 32'(bus.dir_out), 32'(UP));
    tick();
    chk("t2_moved", 32'(bus.moved_out), 0);
    chk_pos("t2_pos", 1, 1);
    bus.blocked_in = 1'b0;
    tick();
    chk("t2_moved_late", 32'(bus.moved_out), 0);

    // 3: edges of the grid
    step_dir(2);
    step_dir(0);
    chk_pos("t3_origin", 0, 0);
    bus.left_in = 1'b1;
    tick();
    bus.left_in = 1'b0;
    chk("t3_qx_lo", 32'(bus.query_x_out), 0);
    chk("t3_qy_lo", 32'(bus.query_y_out), 0);
    chk("t3_dir_lo", 32'(bus.dir_out), 32'(LEFT));
    tick();
    chk("t3_moved_lo", 32'(bus.moved_out), 0);
    chk_pos("t3_pos_lo", 0, 0);
    tick();
    for (int i = 0; i < 3; i++) step_dir(3);
    for (int i = 0; i < 3; i++) step_dir(1);
    chk_pos("t3_corner", 3, 3);
    bus.right_in = 1'b1;
    tick();
    bus.right_in = 1'b0;
    chk("t3_qx_hi", 32'(bus.query_x_out), 3);
    chk("t3_qy_hi", 32'(bus.query_y_out), 3);
    tick();
    chk("t3_moved_hi", 32'(bus.moved_out), 0);
    chk_pos("t3_pos_hi", 3, 3);
    tick();

    // 4: hold-to-repeat along the top row
    for (int i = 0; i < 3; i++) step_dir(2);
    for (int i = 0; i < 3; i++) step_dir(0);
    chk_pos("t4_start", 0, 0);
    bus.right_in = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_x = (k >= 14) ? 3 : (k >= 9) ? 2 : 1;
      chk($sformatf("t4_x_%0d", k), 32'(bus.player_x_out), 32'(exp_x));
      chk($sformatf("t4_mv_%0d", k), 32'(bus.moved_out),
          (k == 1 || k == 9 || k == 14) ? 32'd1 : 32'd0);
    end
    chk("t4_y", 32'(bus.player_y_out), 0);
    bus.right_in = 1'b0;
    tick();
    tick();

    // 5: direction priority and chop
    bus.up_in = 1'b1; bus.left_in = 1'b1;
    tick();
    bus.up_in = 1'b0; bus.left_in = 1'b0;
    chk("t5_dir", 32'(bus.dir_out), 32'(UP));
    chk("t5_qy", 32'(bus.query_y_out), 0);
    tick();
    tick();
    chk_pos("t5_pos", 3, 0);
    bus.chop_in = 1'b1;
    tick();
    chk("t5_chop_on", 32'(bus.chop_out), 1);
    bus.right_in = 1'b1;
    tick();
    chk("t5_chop_dir", 32'(bus.chop_out), 0);
    bus.right_in = 1'b0; bus.chop_in = 1'b0;
    tick();
    chk("t5_moved", 32'(bus.moved_out), 0);
    tick();

    // 6: enable drop and reset while holding down
    bus.down_in = 1'b1;
    tick();
    chk("t6_qy", 32'(bus.query_y_out), 1);
    tick();
    chk("t6_y1", 32'(bus.player_y_out), 1);
    chk("t6_mv1", 32'(bus.moved_out), 1);
    tick();
    bus.enable_in = 1'b0;
    tick();
    chk("t6_state_dis", 32'(dut.r_state), 32'(IDLE));
    chk("t6_mv_dis", 32'(bus.moved_out), 0);
    tick();
    chk_pos("t6_pos_dis", 3, 1);
    chk("t6_dir_dis", 32'(bus.dir_out), 32'(DOWN));
    bus.enable_in = 1'b1;
    tick();
    chk("t6_qy_re", 32'(bus.query_y_out), 2);
    tick();
    chk("t6_y2", 32'(bus.player_y_out), 2);
    chk("t6_mv2", 32'(bus.moved_out), 1);
    tick();
    rst = 1'b1;
    tick();
    bus.down_in = 1'b0;
    chk_pos("t6_rst_pos", 1, 1);
    chk("t6_rst_dir", 32'(bus.dir_out), 32'(DOWN));
    chk("t6_rst_mv", 32'(bus.moved_out), 0);
    chk("t6_rst_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;
    tick();
    tick();
    chk_pos("t6_after", 1, 1);
    chk("t6_after_mv", 32'(bus.moved_out), 0);
    chk("t6_after_chop", 32'(bus.chop_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
